// File: rtl/rst_seq_pkg.sv
// Shared types and default constants for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        RELEASE,
        WAIT_RDY,
        GAP,
        DONE,
        FAULT
    } seq_state_e;

    localparam int STAGE_CYC_DEF = 16;
    localparam int ACK_TO_DEF    = 1024;
    localparam int WDOG_CNT      = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter shared by the HOLD, GAP and WAIT_RDY phases.
module rst_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_DOM reset domains one at a time, waiting for each to report ready.
// Optional DONE-state ready watchdog is built when RST_SEQ_WDOG_EN is defined.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM   = 4,
    parameter int STAGE_CYC = STAGE_CYC_DEF,
    parameter int ACK_TO    = ACK_TO_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sw_rst_req,
    input  logic [NUM_DOM-1:0]         dom_rdy,
    output logic [NUM_DOM-1:0]         dom_rst_n,
    output logic                       seq_done,
    output logic                       fault,
    output logic [$clog2(NUM_DOM)-1:0] fault_dom
);

    localparam int IDX_W = $clog2(NUM_DOM);
    localparam int CNT_W = $clog2(max_int(STAGE_CYC, ACK_TO)) + 1;

    // The timer starts each phase at zero and counts down through the wrap, so
    // "n-1 cycles elapsed" is the fixed pattern 0-(n-1).
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(0 - (STAGE_CYC - 1));
    localparam logic [CNT_W-1:0] ACK_END  = CNT_W'(0 - (ACK_TO - 1));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOM - 1);

    seq_state_e         state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_DOM-1:0] dom_rst_n_q;
    logic               seq_done_q;
    logic               fault_q;
    logic [IDX_W-1:0]   fault_dom_q;

    logic [CNT_W-1:0]   tmr_cnt;
    logic               tmr_load;
    logic               tmr_dec;
    logic               gap_end;
    logic               ack_end;
    logic               rdy_cur;
    logic               wd_trip;
    logic [IDX_W-1:0]   wd_idx;

    assign gap_end = (tmr_cnt == GAP_END);
    assign ack_end = (tmr_cnt == ACK_END);
    assign rdy_cur = dom_rdy[idx_q];

    rst_seq_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i ('0),
        .dec_i      (tmr_dec),
        .cnt_o      (tmr_cnt)
    );

    // NOTE: both outputs get a default first, so no path through this block infers a latch.
    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        if (sw_rst_req) begin
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                HOLD, GAP: begin
                    if (gap_end) tmr_load = 1'b1;
                    else         tmr_dec  = 1'b1;
                end
                WAIT_RDY: begin
                    if (rdy_cur || ack_end) tmr_load = 1'b1;
                    else                    tmr_dec  = 1'b1;
                end
                default: tmr_load = 1'b1;
            endcase
        end
    end

`ifdef RST_SEQ_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CNT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CNT - 1);

    logic [WD_W-1:0] wd_cnt_q [NUM_DOM];

    // NOTE: these few per-domain counters are plain flops, so they are reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DOM; i++) wd_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_DOM; i++) begin
                if (state_q != DONE || sw_rst_req || dom_rdy[i]) wd_cnt_q[i] <= '0;
                else if (wd_cnt_q[i] != WD_LAST)                  wd_cnt_q[i] <= wd_cnt_q[i] + 1'b1;
            end
        end
    end

    // Scan downward so the lowest tripping domain is reported.
    always_comb begin
        wd_trip = 1'b0;
        wd_idx  = '0;
        for (int i = NUM_DOM - 1; i >= 0; i--) begin
            if (!dom_rdy[i] && wd_cnt_q[i] == WD_LAST) begin
                wd_trip = 1'b1;
                wd_idx  = IDX_W'(i);
            end
        end
    end
`else
    assign wd_trip = 1'b0;
    assign wd_idx  = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HOLD;
            idx_q       <= '0;
            dom_rst_n_q <= '0;
            seq_done_q  <= 1'b0;
            fault_q     <= 1'b0;
            fault_dom_q <= '0;
        end else if (sw_rst_req) begin
            state_q     <= HOLD;
            idx_q       <= '0;
            dom_rst_n_q <= '0;
            seq_done_q  <= 1'b0;
            fault_q     <= 1'b0;
            fault_dom_q <= '0;
        end else begin
            case (state_q)
                HOLD: begin
                    dom_rst_n_q <= '0;
                    if (gap_end) state_q <= RELEASE;
                end
                RELEASE: begin
                    dom_rst_n_q[idx_q] <= 1'b1;
                    state_q            <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (rdy_cur) begin
                        if (idx_q == LAST_IDX) begin
                            state_q    <= DONE;
                            seq_done_q <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= GAP;
                        end
                    end else if (ack_end) begin
                        state_q     <= FAULT;
                        dom_rst_n_q <= '0;
                        fault_q     <= 1'b1;
                        fault_dom_q <= idx_q;
                    end
                end
                GAP: begin
                    if (gap_end) state_q <= RELEASE;
                end
                DONE: begin
                    if (wd_trip) begin
                        state_q     <= FAULT;
                        dom_rst_n_q <= '0;
                        seq_done_q  <= 1'b0;
                        fault_q     <= 1'b1;
                        fault_dom_q <= wd_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dom_rst_n = dom_rst_n_q;
    assign seq_done  = seq_done_q;
    assign fault     = fault_q;
    assign fault_dom = fault_dom_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output changes (value and cycle) are queued
// by the stimulus and popped by a monitor whenever the observed outputs change.
module tb_reset_sequencer;

    localparam int N = 4;
    localparam int S = 16;
    localparam int A = 1024;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sw_rst_req = 1'b0;
    logic [N-1:0] dom_rdy = '1;
    logic [N-1:0] dom_rst_n;
    logic         seq_done;
    logic         fault;
    logic [1:0]   fault_dom;

    // {fault_dom, fault, seq_done, dom_rst_n}
    logic [7:0]   obs;
    assign obs = {fault_dom, fault, seq_done, dom_rst_n};

    reset_sequencer #(.NUM_DOM(N), .STAGE_CYC(S), .ACK_TO(A)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
        .dom_rdy    (dom_rdy),
        .dom_rst_n  (dom_rst_n),
        .seq_done   (seq_done),
        .fault      (fault),
        .fault_dom  (fault_dom)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] val;
        string      name;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [7:0] prev_obs = 8'h00;
    int         checks = 0;
    int         errors = 0;

    always @(negedge clk) begin
        if (obs !== prev_obs) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: got %h at cycle %0d, required no change", obs, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (obs !== mon_e.val || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                             mon_e.name, obs, cyc, mon_e.val, mon_e.cyc);
                end
            end
            prev_obs = obs;
        end
    end

    task automatic expect_ev(input int c, input logic [7:0] v, input string n);
        ev_t e;
        e.cyc  = c;
        e.val  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic step_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending events, required 0 (next %s)",
                     tag, exp_q.size(), exp_q[0].name);
            exp_q.delete();
        end
    endtask

    task automatic check(input string n, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", n, got, req);
        end
    endtask

    // Pushes the full release ramp for a sequence whose HOLD phase begins processing at edge x.
    task automatic expect_ramp(input int x, input string tag);
        expect_ev(x + S,          8'h01, {tag, "_dom0"});
        expect_ev(x + S + 18,     8'h03, {tag, "_dom1"});
        expect_ev(x + S + 36,     8'h07, {tag, "_dom2"});
        expect_ev(x + S + 54,     8'h0F, {tag, "_dom3"});
        expect_ev(x + S + 55,     8'h1F, {tag, "_done"});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        int c;

        // Power-on reset
        #1 rst = 1'b1;
        #2 check("reset_state", obs, 8'h00);

        // Full ramp with every domain ready
        step_to(3);
        c = cyc;
        rst = 1'b0;
        expect_ramp(c + 1, "ramp");
        drain(200, "ramp");

        // Domain 2 never ready -> timeout fault
        c = cyc;
        dom_rdy = 4'b1011;
        sw_rst_req = 1'b1;
        expect_ev(c + 1,           8'h00, "sw_clear_done");
        expect_ev(c + 18,          8'h01, "tmo_dom0");
        expect_ev(c + 36,          8'h03, "tmo_dom1");
        expect_ev(c + 54,          8'h07, "tmo_dom2");
        expect_ev(c + 54 + A,      8'hA0, "tmo_fault");
        @(negedge clk);
        sw_rst_req = 1'b0;
        drain(1200, "tmo");

        // Recover from FAULT with a single-cycle software request
        c = cyc;
        dom_rdy = '1;
        sw_rst_req = 1'b1;
        expect_ev(c + 1, 8'h00, "fault_clear");
        expect_ramp(c + 2, "recover");
        @(negedge clk);
        sw_rst_req = 1'b0;
        drain(200, "recover");

        // Restart collides with ready, then held request, then async reset mid-GAP
        c = cyc;
        dom_rdy = '0;
        sw_rst_req = 1'b1;
        expect_ev(c + 1,  8'h00, "coll_clear");
        expect_ev(c + 18, 8'h01, "coll_dom0");
        @(negedge clk);
        sw_rst_req = 1'b0;
        drain(100, "coll_pre");
        step_to(c + 22);
        sw_rst_req = 1'b1;
        dom_rdy = 4'b0011;
        expect_ev(c + 23, 8'h00, "coll_restart_wins");
        expect_ev(c + 42, 8'h01, "held_req_dom0");
        expect_ev(c + 60, 8'h03, "held_req_dom1");
        repeat (3) @(negedge clk);
        sw_rst_req = 1'b0;
        drain(100, "coll");
        step_to(c + 68);
        #2;
        expect_ev(c + 69, 8'h00, "async_rst_event");
        rst = 1'b1;
        #1 check("async_rst_now", {4'h0, dom_rst_n}, 8'h00);
        step_to(c + 71);
        c = cyc;
        dom_rdy = '1;
        rst = 1'b0;
        expect_ramp(c + 1, "post_rst");
        drain(200, "post_rst");

`ifdef RST_SEQ_WDOG_EN
        // Watchdog: a 7-cycle drop is tolerated, an 8-cycle drop trips
        dom_rdy = 4'b1101;
        repeat (7) @(negedge clk);
        dom_rdy = '1;
        repeat (10) @(negedge clk);
        check("wdog_short_drop", obs, 8'h1F);
        c = cyc;
        dom_rdy = 4'b1101;
        expect_ev(c + 8, 8'h60, "wdog_fault");
        drain(40, "wdog");
`else
        // Without the watchdog, ready bits are ignored once DONE
        dom_rdy = '0;
        repeat (20) @(negedge clk);
        dom_rdy = '1;
        repeat (2) @(negedge clk);
        check("done_ignores_rdy", obs, 8'h1F);
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
